// File: rtl/caster_pkg.sv
// rtl/caster_pkg.sv - shared constants and types for the caster write-back path
package caster_pkg;

    localparam int MEM_WORD_BYTES = 8;
    localparam int MEM_BL_W       = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CMD  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/vram_writeback_if.sv
// rtl/vram_writeback_if.sv - memory-controller write port: data channel plus burst command channel
interface vram_writeback_if #(
    parameter int ADDR_W = 30
);
    import caster_pkg::*;

    logic                mem_wr_valid;
    logic                mem_wr_ready;
    logic [63:0]         mem_wr_data;
    logic                mem_cmd_valid;
    logic                mem_cmd_ready;
    logic [ADDR_W-1:0]   mem_cmd_addr;
    logic [MEM_BL_W-1:0] mem_cmd_bl;

    modport master (
        output mem_wr_valid, mem_wr_data, mem_cmd_valid, mem_cmd_addr, mem_cmd_bl,
        input  mem_wr_ready, mem_cmd_ready
    );

    modport slave (
        input  mem_wr_valid, mem_wr_data, mem_cmd_valid, mem_cmd_addr, mem_cmd_bl,
        output mem_wr_ready, mem_cmd_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - first-word-fall-through FIFO with synchronous clear and occupancy output
module wb_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Clear moves the read pointer to the pre-push write pointer, so a same-cycle push survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_clear) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/vram_writeback.sv
// rtl/vram_writeback.sv - buffers EPD pixel-state words and drains them as DDR write bursts
// Optional CASTER_WB_FLUSH_EN: flush a partial burst after FLUSH_IDLE idle input cycles.
module vram_writeback
    import caster_pkg::*;
#(
    parameter int                ADDR_W     = 30,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 64,
    parameter int                BURST_LEN  = 16,
    parameter int                FLUSH_IDLE = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          b_trigger,
    input  logic [63:0]                   bo_pixel,
    input  logic                          bo_valid,
    vram_writeback_if.master              mem,
    output logic                          status_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   status_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2*BURST_LEN || BURST_LEN < 1 || BURST_LEN > 64 || FLUSH_IDLE < 1) begin : g_bad_param
        $error("vram_writeback: illegal parameter combination");
    end

    wb_state_t           r_state;
    logic [6:0]          r_burst_words;
    logic [6:0]          r_pop_cnt;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [MEM_BL_W-1:0] r_cmd_bl;
    logic                r_trig_d;
    logic                r_trig_pend;
    logic                r_ovf;

    logic [63:0]         w_head;
    logic [LVL_W-1:0]    w_level;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_valid;
    logic                w_pop;
    logic                w_start;
    logic                w_trig_svc;
    logic [6:0]          w_start_words;
    logic [ADDR_W-1:0]   w_burst_bytes;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bo_valid),
        .i_wdata (bo_pixel),
        .i_pop   (w_pop),
        .i_clear (w_trig_svc),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef CASTER_WB_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_IDLE + 1);
    logic [IDLE_W-1:0] r_idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (bo_valid) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_W'(FLUSH_IDLE)) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end

    // Full bursts first, then a short flush of residue; a frame restart waits for an empty FIFO.
    always_comb begin
        w_start       = 1'b0;
        w_trig_svc    = 1'b0;
        w_start_words = 7'(BURST_LEN);
        if (r_state == IDLE) begin
            if (w_level >= LVL_W'(BURST_LEN)) begin
                w_start = 1'b1;
            end else if (!w_empty && r_idle_cnt == IDLE_W'(FLUSH_IDLE)) begin
                w_start       = 1'b1;
                w_start_words = 7'(w_level);
            end else if (r_trig_pend && w_empty) begin
                w_trig_svc = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_start       = 1'b0;
        w_trig_svc    = 1'b0;
        w_start_words = 7'(BURST_LEN);
        if (r_state == IDLE) begin
            if (r_trig_pend) begin
                w_trig_svc = 1'b1;
            end else if (w_level >= LVL_W'(BURST_LEN)) begin
                w_start = 1'b1;
            end
        end
    end
`endif

    assign w_wr_valid    = (r_state == DATA) && !w_empty;
    assign w_pop         = w_wr_valid & mem.mem_wr_ready;
    assign w_burst_bytes = ADDR_W'(r_burst_words) * ADDR_W'(MEM_WORD_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_burst_words <= '0;
            r_pop_cnt     <= '0;
            r_wr_addr     <= BASE_ADDR;
            r_cmd_bl      <= '0;
            r_trig_d      <= 1'b0;
            r_trig_pend   <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_trig_d <= b_trigger;
            if (b_trigger && !r_trig_d) begin
                r_trig_pend <= 1'b1;
            end else if (w_trig_svc) begin
                r_trig_pend <= 1'b0;
            end
            if (bo_valid && w_full) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_trig_svc) begin
                        r_wr_addr <= BASE_ADDR;
                    end else if (w_start) begin
                        r_state       <= DATA;
                        r_burst_words <= w_start_words;
                        r_cmd_bl      <= MEM_BL_W'(w_start_words - 7'd1);
                        r_pop_cnt     <= '0;
                    end
                end
                DATA: begin
                    if (w_pop) begin
                        r_pop_cnt <= r_pop_cnt + 7'd1;
                        if (r_pop_cnt == r_burst_words - 7'd1) begin
                            r_state <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (mem.mem_cmd_ready) begin
                        r_wr_addr <= r_wr_addr + w_burst_bytes;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_wr_valid  = w_wr_valid;
    assign mem.mem_wr_data   = w_wr_valid ? w_head : 64'd0;
    assign mem.mem_cmd_valid = (r_state == CMD);
    assign mem.mem_cmd_addr  = r_wr_addr;
    assign mem.mem_cmd_bl    = r_cmd_bl;
    assign status_ovf        = r_ovf;
    assign status_level      = w_level;

endmodule

// File: tb/tb_vram_writeback.sv
// tb/tb_vram_writeback.sv - scoreboard bench for vram_writeback
module tb_vram_writeback;
    import caster_pkg::*;

    localparam int ADDR_W = 30;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        b_trigger = 1'b0;
    logic [63:0] bo_pixel  = '0;
    logic        bo_valid  = 1'b0;
    logic        status_ovf;
    logic [6:0]  status_level;

    vram_writeback_if #(.ADDR_W(ADDR_W)) mem_if ();

    vram_writeback #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (30'h0),
        .FIFO_DEPTH (64),
        .BURST_LEN  (16),
        .FLUSH_IDLE (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .b_trigger    (b_trigger),
        .bo_pixel     (bo_pixel),
        .bo_valid     (bo_valid),
        .mem          (mem_if),
        .status_ovf   (status_ovf),
        .status_level (status_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_data[$];
    logic [35:0] exp_cmd[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every handshake seen on the memory port is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && mem_if.mem_wr_valid && mem_if.mem_wr_ready) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_data: got unexpected word %0h expected none", mem_if.mem_wr_data);
            end else begin
                chk("wr_data", mem_if.mem_wr_data, exp_data.pop_front());
            end
        end
        if (rst_n && mem_if.mem_cmd_valid && mem_if.mem_cmd_ready) begin
            if (exp_cmd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd: got unexpected addr %0h bl %0d expected none",
                         mem_if.mem_cmd_addr, mem_if.mem_cmd_bl);
            end else begin
                logic [35:0] c;
                c = exp_cmd.pop_front();
                chk("cmd_addr", 64'(mem_if.mem_cmd_addr), 64'(c[35:6]));
                chk("cmd_bl", 64'(mem_if.mem_cmd_bl), 64'(c[5:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_burst(input logic [29:0] addr, input logic [5:0] bl);
        exp_cmd.push_back({addr, bl});
    endtask

    task automatic push_words(input logic [63:0] tag, input int n, input int n_exp);
        for (int i = 0; i < n; i++) begin
            bo_valid = 1'b1;
            bo_pixel = tag | 64'(i);
            if (i < n_exp) exp_data.push_back(bo_pixel);
            tick();
        end
        bo_valid = 1'b0;
    endtask

    task automatic pulse_trigger();
        b_trigger = 1'b1;
        tick();
        b_trigger = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_data.size() != 0 || exp_cmd.size() != 0 ||
                mem_if.mem_wr_valid || mem_if.mem_cmd_valid) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: got drain timeout with %0d words %0d cmds left expected empty",
                     name, exp_data.size(), exp_cmd.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        mem_if.mem_wr_ready  = 1'b1;
        mem_if.mem_cmd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_wr_valid",  64'(mem_if.mem_wr_valid), 64'd0);
        chk("rst_cmd_valid", 64'(mem_if.mem_cmd_valid), 64'd0);
        chk("rst_wr_data",   mem_if.mem_wr_data, 64'd0);
        chk("rst_cmd_addr",  64'(mem_if.mem_cmd_addr), 64'h0);
        chk("rst_cmd_bl",    64'(mem_if.mem_cmd_bl), 64'd0);
        chk("rst_ovf",       64'(status_ovf), 64'd0);
        chk("rst_level",     64'(status_level), 64'd0);
        rst_n = 1'b1;
        tick();

        // Steady stream: two full bursts at 0x0 and 0x80.
        pulse_trigger();
        exp_burst(30'h0, 6'd15);
        exp_burst(30'h80, 6'd15);
        push_words(64'hA000_0000_0000_0000, 32, 32);
        wait_drain("steady");
        chk("steady_ovf", 64'(status_ovf), 64'd0);
        chk("steady_level", 64'(status_level), 64'd0);

        // Backpressure: 70 words into a 64-deep FIFO, 6 dropped.
        pulse_trigger();
        mem_if.mem_wr_ready = 1'b0;
        for (int b = 0; b < 4; b++) exp_burst(30'(b * 'h80), 6'd15);
        push_words(64'hB000_0000_0000_0000, 70, 64);
        repeat (30) tick();
        chk("bp_level", 64'(status_level), 64'd64);
        chk("bp_ovf", 64'(status_ovf), 64'd1);
        chk("bp_wr_valid", 64'(mem_if.mem_wr_valid), 64'd1);
        chk("bp_head", mem_if.mem_wr_data, 64'hB000_0000_0000_0000);
        mem_if.mem_wr_ready = 1'b1;
        wait_drain("backpressure");

        // Command stall: command fields hold and no new burst begins until accepted.
        pulse_trigger();
        mem_if.mem_cmd_ready = 1'b0;
        exp_burst(30'h0, 6'd15);
        exp_burst(30'h80, 6'd15);
        push_words(64'hC000_0000_0000_0000, 32, 32);
        n = 0;
        while (!mem_if.mem_cmd_valid && n < 200) begin
            tick();
            n++;
        end
        chk("stall_cmd_seen", 64'(mem_if.mem_cmd_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            chk("stall_cmd_valid", 64'(mem_if.mem_cmd_valid), 64'd1);
            chk("stall_cmd_addr", 64'(mem_if.mem_cmd_addr), 64'h0);
            chk("stall_cmd_bl", 64'(mem_if.mem_cmd_bl), 64'd15);
            chk("stall_no_data", 64'(mem_if.mem_wr_valid), 64'd0);
            tick();
        end
        mem_if.mem_cmd_ready = 1'b1;
        wait_drain("cmd_stall");

        // Trigger during the 0x200 burst: it finishes there, residue handled, restart at base.
        pulse_trigger();
        for (int b = 0; b < 4; b++) exp_burst(30'(b * 'h80), 6'd15);
        push_words(64'hD000_0000_0000_0000, 64, 64);
        wait_drain("pre_trigger");
        exp_burst(30'h200, 6'd15);
`ifdef CASTER_WB_FLUSH_EN
        exp_burst(30'h280, 6'd4);
        push_words(64'hE000_0000_0000_0000, 21, 21);
`else
        push_words(64'hE000_0000_0000_0000, 21, 16);
`endif
        chk("trig_in_data", 64'(mem_if.mem_wr_valid), 64'd1);
        pulse_trigger();
        wait_drain("trigger_burst");
        repeat (4) tick();
        chk("trig_level", 64'(status_level), 64'd0);
        chk("trig_addr", 64'(mem_if.mem_cmd_addr), 64'h0);
        exp_burst(30'h0, 6'd15);
        push_words(64'hF000_0000_0000_0000, 16, 16);
        wait_drain("post_trigger");

        // Reset during DATA: outputs drop asynchronously, FIFO emptied, address back to base.
        chk("ovf_sticky", 64'(status_ovf), 64'd1);
        mem_if.mem_wr_ready = 1'b0;
        push_words(64'h1111_0000_0000_0000, 16, 0);
        chk("start_level", 64'(status_level), 64'd16);
        chk("start_not_yet", 64'(mem_if.mem_wr_valid), 64'd0);
        tick();
        chk("start_data", 64'(mem_if.mem_wr_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_valid", 64'(mem_if.mem_wr_valid), 64'd0);
        chk("arst_wr_data", mem_if.mem_wr_data, 64'd0);
        chk("arst_level", 64'(status_level), 64'd0);
        chk("arst_ovf", 64'(status_ovf), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        mem_if.mem_wr_ready = 1'b1;
        tick();
        chk("post_rst_level", 64'(status_level), 64'd0);
        chk("post_rst_addr", 64'(mem_if.mem_cmd_addr), 64'h0);
        exp_burst(30'h0, 6'd15);
        push_words(64'h2222_0000_0000_0000, 16, 16);
        wait_drain("post_reset");

`ifdef CASTER_WB_FLUSH_EN
        // Idle flush: 5 words go out as a short burst, next burst 0x28 further on.
        pulse_trigger();
        exp_burst(30'h0, 6'd4);
        push_words(64'h3333_0000_0000_0000, 5, 5);
        repeat (10) tick();
        chk("flush_not_early", 64'(mem_if.mem_wr_valid), 64'd0);
        wait_drain("flush");
        exp_burst(30'h28, 6'd15);
        push_words(64'h4444_0000_0000_0000, 16, 16);
        wait_drain("post_flush");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
